// File: rtl/pipe_arbiter_pkg.sv
// Shared constants and width helpers for the pipe_arbiter block.
// Holds the default requester count, data width and pipeline latency,
// plus the clog2-based helpers that size requester ids and the in-flight counter.
package pipe_arbiter_pkg;

  // Default configuration: four requesters, 16-bit words, two-stage pipeline.
  localparam int DEF_NREQ    = 4;
  localparam int DEF_W       = 16;
  localparam int DEF_LATENCY = 2;

  // Ceiling log2; returns 0 for values of 0 or 1.
  function automatic int clog2(input int value);
    int result;
    int v;
    result = 0;
    v      = value - 1;
    while (v > 0) begin
      result = result + 1;
      v      = v >> 1;
    end
    return result;
  endfunction

  // Width of a requester id; never narrower than one bit.
  function automatic int id_width(input int nreq);
    return (clog2(nreq) < 1) ? 1 : clog2(nreq);
  endfunction

  // Width of a counter that must hold 0..latency inclusive; at least one bit.
  function automatic int cnt_width(input int latency);
    return (clog2(latency + 1) < 1) ? 1 : clog2(latency + 1);
  endfunction

endpackage : pipe_arbiter_pkg

// File: rtl/pipe_arbiter_rr.sv
// Round-robin selector: picks the first eligible requester at or above the pointer.
// Latency: purely combinational, grant is valid in the same cycle as eligible.
// Backpressure: none; an empty eligible set simply yields an all-zero grant.
//
// Ports:
//   eligible  [NREQ]  requesters that may be granted this cycle
//   pointer   [IDW]   index where the upward scan starts (0..NREQ-1)
//   grant     [NREQ]  one-hot grant, all-zero when nothing is eligible
//   grant_idx [IDW]   binary index of the granted requester (0 when no grant)
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic [NREQ-1:0] eligible,
  input  logic [IDW-1:0]  pointer,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  grant_idx
);

  // One extra bit so pointer + offset never overflows before the wrap.
  logic [IDW:0]   sum;
  logic [IDW-1:0] idx;
  logic           found;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    sum       = '0;
    idx       = '0;
    // Walk offsets 0..NREQ-1 from the pointer; the first hit wins, which
    // gives the wrap NREQ-1 -> 0 without a doubled request vector.
    for (int k = 0; k < NREQ; k++) begin
      sum = {1'b0, pointer} + (IDW+1)'(k);
      if (sum >= (IDW+1)'(NREQ)) begin
        sum = sum - (IDW+1)'(NREQ);
      end
      idx = sum[IDW-1:0];
      if (!found && eligible[idx]) begin
        found       = 1'b1;
        grant[idx]  = 1'b1;
        grant_idx   = idx;
      end
    end
  end

endmodule : rr_arbiter

// File: rtl/pipe_arbiter.sv
// Shares one external fixed-latency pipeline among NREQ requesters, round-robin.
// Latency: grant is combinational; rsp_valid fires exactly LATENCY cycles after the grant.
// Backpressure: one grant per cycle via req_ready; responses cannot be stalled.
//
// Ports:
//   clk, rst                 clock; asynchronous active-high reset
//   req_valid/req_mask [N]   request strobes and per-requester enables
//   req_data [N*W]           request words, requester i at [i*W +: W]
//   req_ready [N]            one-hot grant (transfer on valid & ready)
//   pipe_ivalid/pipe_idata   word launched into the shared pipeline
//   pipe_odata [W]           pipeline result, LATENCY cycles after launch
//   rsp_valid [N]/rsp_data   one-hot response strobe and pass-through result
//   busy                     requests eligible or words still in flight
module pipe_arbiter
  import pipe_arbiter_pkg::*;
#(
  parameter int NREQ    = DEF_NREQ,
  parameter int W       = DEF_W,
  parameter int LATENCY = DEF_LATENCY
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ*W-1:0] req_data,
  input  logic [NREQ-1:0]   req_mask,
  output logic [NREQ-1:0]   req_ready,
  output logic              pipe_ivalid,
  output logic [W-1:0]      pipe_idata,
  input  logic [W-1:0]      pipe_odata,
  output logic [NREQ-1:0]   rsp_valid,
  output logic [W-1:0]      rsp_data,
  output logic              busy
);

  localparam int IDW  = id_width(NREQ);
  localparam int CNTW = cnt_width(LATENCY);

  logic [NREQ-1:0] eligible;
  logic [NREQ-1:0] grant;
  logic [IDW-1:0]  grant_idx;
  logic [IDW-1:0]  ptr_q;
  logic [IDW-1:0]  ptr_d;
  logic [NREQ-1:0] rsp_vec;
  logic            rsp_any;
  logic [CNTW-1:0] cnt_q;

  // Reset is asynchronous, so the eligible set is blanked combinationally
  // to keep req_ready, pipe_ivalid and pipe_idata low while rst is high.
  assign eligible = rst ? '0 : (req_valid & req_mask);

  rr_arbiter #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_rr (
    .eligible  (eligible),
    .pointer   (ptr_q),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  assign req_ready   = grant;
  assign pipe_ivalid = |grant;

  // AND-OR mux of the granted word; yields zero when there is no grant.
  always_comb begin
    pipe_idata = '0;
    for (int i = 0; i < NREQ; i++) begin
      pipe_idata = pipe_idata | (req_data[i*W +: W] & {W{grant[i]}});
    end
  end

  // Pointer moves to one past the winner; it holds when nothing is granted.
  always_comb begin
    ptr_d = ptr_q;
    if (pipe_ivalid) begin
      ptr_d = (grant_idx == IDW'(NREQ - 1)) ? '0 : grant_idx + IDW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  // Tag line: {valid, id} travels beside each launched word so the result
  // leaving the external pipeline can be routed back to its owner. The
  // owner is captured at grant time, so later mask changes cannot drop it.
  generate
    if (LATENCY > 0) begin : g_tag
      logic [LATENCY-1:0] tag_vld_q;
      logic [IDW-1:0]     tag_id_q [LATENCY];

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          tag_vld_q <= '0;
          for (int s = 0; s < LATENCY; s++) begin
            tag_id_q[s] <= '0;
          end
        end else begin
          tag_vld_q[0] <= pipe_ivalid;
          tag_id_q[0]  <= grant_idx;
          for (int s = 1; s < LATENCY; s++) begin
            tag_vld_q[s] <= tag_vld_q[s-1];
            tag_id_q[s]  <= tag_id_q[s-1];
          end
        end
      end

      always_comb begin
        rsp_vec = '0;
        if (tag_vld_q[LATENCY-1]) begin
          rsp_vec[tag_id_q[LATENCY-1]] = 1'b1;
        end
      end
    end else begin : g_bypass
      // Zero-latency pipeline: the response belongs to this cycle's grant.
      assign rsp_vec = grant;
    end
  endgenerate

  assign rsp_valid = rsp_vec;
  assign rsp_data  = pipe_odata;
  assign rsp_any   = |rsp_vec;

  // In-flight count mirrors the number of live tags, so it is bounded by
  // LATENCY by construction; a grant and a response together cancel out.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (pipe_ivalid && !rsp_any) begin
      cnt_q <= cnt_q + CNTW'(1);
    end else if (!pipe_ivalid && rsp_any) begin
      cnt_q <= cnt_q - CNTW'(1);
    end
  end

  assign busy = (cnt_q != '0) | (|eligible);

endmodule : pipe_arbiter

// File: tb/tb_pipe_arbiter.sv
// Directed bench for pipe_arbiter: a LATENCY=2 instance with a two-register
// pipeline model, and a LATENCY=0 instance with an inverting combinational pipeline.
module tb_pipe_arbiter;

  logic        clk;
  logic        rst;
  logic [3:0]  req_valid;
  logic [63:0] req_data;
  logic [3:0]  req_mask;

  logic [3:0]  req_ready;
  logic        pipe_ivalid;
  logic [15:0] pipe_idata;
  logic [15:0] pipe_odata;
  logic [3:0]  rsp_valid;
  logic [15:0] rsp_data;
  logic        busy;

  logic [3:0]  req_ready_z;
  logic        pipe_ivalid_z;
  logic [15:0] pipe_idata_z;
  logic [15:0] pipe_odata_z;
  logic [3:0]  rsp_valid_z;
  logic [15:0] rsp_data_z;
  logic        busy_z;

  logic [15:0] pd1;
  logic [15:0] pd2;

  int n_cmp;
  int n_bad;

  pipe_arbiter #(.NREQ(4), .W(16), .LATENCY(2)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_mask    (req_mask),
    .req_ready   (req_ready),
    .pipe_ivalid (pipe_ivalid),
    .pipe_idata  (pipe_idata),
    .pipe_odata  (pipe_odata),
    .rsp_valid   (rsp_valid),
    .rsp_data    (rsp_data),
    .busy        (busy)
  );

  pipe_arbiter #(.NREQ(4), .W(16), .LATENCY(0)) dut_z (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_mask    (req_mask),
    .req_ready   (req_ready_z),
    .pipe_ivalid (pipe_ivalid_z),
    .pipe_idata  (pipe_idata_z),
    .pipe_odata  (pipe_odata_z),
    .rsp_valid   (rsp_valid_z),
    .rsp_data    (rsp_data_z),
    .busy        (busy_z)
  );

  // External pipeline models.
  always @(posedge clk) begin
    pd1 <= pipe_idata;
    pd2 <= pd1;
  end
  assign pipe_odata   = pd2;
  assign pipe_odata_z = pipe_idata_z ^ 16'hFFFF;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    step();
    rst       = 1'b1;
    req_valid = '0;
    req_mask  = 4'hF;
    req_data  = '0;
  endtask

  task automatic test_reset();
    step();
    req_valid = 4'hF;
    req_mask  = 4'hF;
    req_data  = 64'h4444_3333_2222_1111;
    #1;
    n_cmp++; if (req_ready !== 4'b0000) begin n_bad++; $display("FAIL reset_ready: got %b want 0000", req_ready); end
    n_cmp++; if (pipe_ivalid !== 1'b0) begin n_bad++; $display("FAIL reset_ivalid: got %b want 0", pipe_ivalid); end
    n_cmp++; if (pipe_idata !== 16'h0000) begin n_bad++; $display("FAIL reset_idata: got %h want 0000", pipe_idata); end
    n_cmp++; if (rsp_valid !== 4'b0000) begin n_bad++; $display("FAIL reset_rsp: got %b want 0000", rsp_valid); end
  endtask

  task automatic test_round_robin();
    logic [3:0]  er;
    logic [3:0]  ev;
    logic [15:0] ed;
    apply_reset();
    for (int i = 0; i < 4; i++) req_data[i*16 +: 16] = 16'h1000 + 16'(i);
    for (int n = 0; n < 10; n++) begin
      step();
      rst       = 1'b0;
      req_valid = 4'hF;
      #1;
      er = 4'(1 << (n % 4));
      ed = 16'h1000 + 16'(n % 4);
      ev = (n >= 2) ? 4'(1 << ((n - 2) % 4)) : 4'b0000;
      n_cmp++; if (req_ready !== er) begin n_bad++; $display("FAIL rr_ready c%0d: got %b want %b", n, req_ready, er); end
      n_cmp++; if (pipe_idata !== ed) begin n_bad++; $display("FAIL rr_idata c%0d: got %h want %h", n, pipe_idata, ed); end
      n_cmp++; if (rsp_valid !== ev) begin n_bad++; $display("FAIL rr_rsp c%0d: got %b want %b", n, rsp_valid, ev); end
      n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL rr_busy c%0d: got %b want 1", n, busy); end
      if (n >= 2) begin
        ed = 16'h1000 + 16'((n - 2) % 4);
        n_cmp++; if (rsp_data !== ed) begin n_bad++; $display("FAIL rr_rdata c%0d: got %h want %h", n, rsp_data, ed); end
      end
    end
    req_valid = '0;
  endtask

  task automatic test_single();
    logic [15:0] ed;
    logic [3:0]  ev;
    logic        eb;
    apply_reset();
    for (int n = 0; n < 8; n++) begin
      step();
      rst       = 1'b0;
      req_valid = (n < 5) ? 4'b0100 : 4'b0000;
      req_data[2*16 +: 16] = 16'h0A00 + 16'(n);
      #1;
      ed = (n < 5) ? 16'h0A00 + 16'(n) : 16'h0000;
      ev = (n >= 2 && n < 7) ? 4'b0100 : 4'b0000;
      eb = (n < 7);
      n_cmp++; if (pipe_idata !== ed) begin n_bad++; $display("FAIL single_idata c%0d: got %h want %h", n, pipe_idata, ed); end
      n_cmp++; if (pipe_ivalid !== (n < 5)) begin n_bad++; $display("FAIL single_ivalid c%0d: got %b", n, pipe_ivalid); end
      n_cmp++; if (rsp_valid !== ev) begin n_bad++; $display("FAIL single_rsp c%0d: got %b want %b", n, rsp_valid, ev); end
      n_cmp++; if (busy !== eb) begin n_bad++; $display("FAIL single_busy c%0d: got %b want %b", n, busy, eb); end
      if (n >= 2 && n < 7) begin
        ed = 16'h0A00 + 16'(n - 2);
        n_cmp++; if (rsp_data !== ed) begin n_bad++; $display("FAIL single_rdata c%0d: got %h want %h", n, rsp_data, ed); end
      end
    end
  endtask

  task automatic test_wrap();
    logic [3:0] er [4];
    er[0] = 4'b0100;
    er[1] = 4'b1000;
    er[2] = 4'b0001;
    er[3] = 4'b1000;
    apply_reset();
    for (int n = 0; n < 4; n++) begin
      step();
      rst       = 1'b0;
      req_valid = (n == 0) ? 4'b0100 : 4'b1001;
      #1;
      n_cmp++; if (req_ready !== er[n]) begin n_bad++; $display("FAIL wrap_ready c%0d: got %b want %b", n, req_ready, er[n]); end
    end
    req_valid = '0;
  endtask

  task automatic test_reset_inflight();
    apply_reset();
    for (int n = 0; n < 6; n++) begin
      step();
      rst       = (n == 2);
      req_valid = (n <= 2) ? 4'b0011 : 4'b0000;
      #1;
      if (n == 2) begin
        n_cmp++; if (req_ready !== 4'b0000) begin n_bad++; $display("FAIL rstfl_ready: got %b want 0000", req_ready); end
        n_cmp++; if (pipe_ivalid !== 1'b0) begin n_bad++; $display("FAIL rstfl_ivalid: got %b want 0", pipe_ivalid); end
      end
      if (n >= 2) begin
        n_cmp++; if (rsp_valid !== 4'b0000) begin n_bad++; $display("FAIL rstfl_rsp c%0d: got %b want 0000", n, rsp_valid); end
      end
      if (n >= 3) begin
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rstfl_busy c%0d: got %b want 0", n, busy); end
      end
    end
  endtask

  task automatic test_mask();
    logic [3:0] ev;
    apply_reset();
    req_data[1*16 +: 16] = 16'h0B11;
    for (int n = 0; n < 4; n++) begin
      step();
      rst       = 1'b0;
      req_valid = 4'b0010;
      req_mask  = (n == 0) ? 4'hF : 4'b1101;
      #1;
      ev = (n == 2) ? 4'b0010 : 4'b0000;
      n_cmp++; if (req_ready !== ((n == 0) ? 4'b0010 : 4'b0000)) begin n_bad++; $display("FAIL mask_ready c%0d: got %b", n, req_ready); end
      n_cmp++; if (rsp_valid !== ev) begin n_bad++; $display("FAIL mask_rsp c%0d: got %b want %b", n, rsp_valid, ev); end
      n_cmp++; if (busy !== (n < 3)) begin n_bad++; $display("FAIL mask_busy c%0d: got %b", n, busy); end
      if (n == 2) begin
        n_cmp++; if (rsp_data !== 16'h0B11) begin n_bad++; $display("FAIL mask_rdata: got %h want 0b11", rsp_data); end
      end
    end
    req_valid = '0;
    req_mask  = 4'hF;
  endtask

  task automatic test_latency0();
    apply_reset();
    req_data[1*16 +: 16] = 16'h1234;
    step();
    rst       = 1'b0;
    req_valid = 4'b0010;
    #1;
    n_cmp++; if (req_ready_z !== 4'b0010) begin n_bad++; $display("FAIL l0_ready: got %b want 0010", req_ready_z); end
    n_cmp++; if (rsp_valid_z !== 4'b0010) begin n_bad++; $display("FAIL l0_rsp: got %b want 0010", rsp_valid_z); end
    n_cmp++; if (pipe_idata_z !== 16'h1234) begin n_bad++; $display("FAIL l0_idata: got %h want 1234", pipe_idata_z); end
    n_cmp++; if (rsp_data_z !== 16'hEDCB) begin n_bad++; $display("FAIL l0_rdata: got %h want edcb", rsp_data_z); end
    n_cmp++; if (busy_z !== 1'b1) begin n_bad++; $display("FAIL l0_busy: got %b want 1", busy_z); end
    step();
    req_valid = 4'b0000;
    #1;
    n_cmp++; if (rsp_valid_z !== 4'b0000) begin n_bad++; $display("FAIL l0_rsp_idle: got %b want 0000", rsp_valid_z); end
    n_cmp++; if (busy_z !== 1'b0) begin n_bad++; $display("FAIL l0_busy_idle: got %b want 0", busy_z); end
  endtask

  initial begin
    n_cmp     = 0;
    n_bad     = 0;
    rst       = 1'b1;
    req_valid = '0;
    req_mask  = 4'hF;
    req_data  = '0;
    test_reset();
    test_round_robin();
    test_single();
    test_wrap();
    test_reset_inflight();
    test_mask();
    test_latency0();
    step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_pipe_arbiter
